rom_load_sched: RTL
===================

Name: rom_load_sched

Overview:
- Sequences the HPS ioctl download stream into the core's storage regions: CPU program ROM, graphics ROMs, sound ROM and a spare region.
- Issues one-byte writes to the owning region and back-pressures the HPS with ioctl_wait while a target region is busy.
- Latches the mod byte (index 1) and the 8 DIP bytes (index 254).
- Owns the core reset: the CPU, video and sound boards are held in reset during a ROM download and for a fixed settle time after it.
- Sits between hps_io and mylstar_board / ma216_board in clk_sys.

Parameters:
- R1_BASE, 25'h0_C000: first byte of region 1 (gfx); region 0 (CPU ROM) is 0 to R1_BASE-1.
- R2_BASE, 25'h1_C000: first byte of region 2 (sound ROM).
- R3_BASE, 25'h1_D000: first byte of region 3 (spare).
- ROM_END, 25'h2_0000: first address past region 3; bytes at or above it are dropped.
- RESET_HOLD, 16: clk_sys cycles core_reset stays high after download falls.
- ROM_INDEX, 8'd0: ioctl_index for ROM data.
- MOD_INDEX, 8'd1: ioctl_index for the mod byte.
- DIP_INDEX, 8'd254: ioctl_index for DIP bytes.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  byte strobe, one cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  download type
- ioctl_wait  out  1  HPS stall request
- region_busy  in  4  per-region target cannot accept a write this cycle
- region_we  out  4  one-hot write strobe
- region_addr  out  17  address relative to region base
- region_data  out  8  write data
- core_reset  out  1  active-high reset to game boards
- mod  out  8  game model byte
- dip_sw  out  64  DIP bytes; byte k in bits [8k+7:8k]
- overflow  out  1  sticky: a ROM byte at or above ROM_END was dropped

Behaviour:
- Reset (async, reset_n=0) values:
  - ioctl_wait=0, region_we=0, region_addr=0, region_data=0.
  - core_reset=1, mod=8'hFF, dip_sw=0, overflow=0.
  - FSM state = HOLD, hold counter = 0.
- FSM states: IDLE, WRITE, HOLD, RUN.
- RUN: core_reset=0. A cycle with ioctl_download=1 and ioctl_index==ROM_INDEX moves to IDLE, and core_reset=1 from the next cycle.
- IDLE (download active):
  - On ioctl_wr with index ROM_INDEX: capture the address, data and decoded region; assert ioctl_wait next cycle; go to WRITE.
  - Region decode: region = highest k with addr >= Rk_BASE. region_addr = addr - base, truncated to 17 bits.
  - addr >= ROM_END: byte dropped, overflow set to 1, stay in IDLE, no wait asserted.
  - Falling ioctl_download goes to HOLD with the counter cleared.
- WRITE:
  - If region_busy[r]=0: region_we[r]=1 for exactly one cycle, and ioctl_wait drops in the same cycle.
  - Minimum latency: ioctl_wr at cycle N gives region_we at N+1.
  - Busy stalls indefinitely, holding wait, address and data stable.
  - Return to IDLE after the write. An ioctl_wr while ioctl_wait is high is a protocol violation and is ignored.
- HOLD:
  - core_reset=1; the counter increments each cycle.
  - At count RESET_HOLD-1 go to RUN; core_reset falls on the next edge.
  - A new ROM download during HOLD returns to IDLE.
- MOD and DIP indices are handled in any state, with no wait and no core_reset change:
  - MOD_INDEX: mod <= ioctl_dout on every ioctl_wr; the last byte wins.
  - DIP_INDEX: on ioctl_wr with addr[24:3]==0, dip_sw byte addr[2:0] <= ioctl_dout. Higher addresses are ignored.
- Simultaneous events:
  - ioctl_download falling in WRITE: the pending write completes first, then HOLD.
  - reset_n low mid-write aborts the write with no strobe.
- overflow clears only on reset_n or at the start of a new ROM download.

Optional Feature:
- Macro: ROM_LOAD_CHECKSUM_EN.
- Defined:
  - Adds output rom_sum[15:0], a wrapping sum of every accepted ROM byte (dropped bytes excluded).
  - rom_sum clears when IDLE is entered from RUN or HOLD, and is frozen in RUN.
- Not defined: no port and no adder.

Decomposition:
- Package rom_load_pkg holds:
  - state enum state_t {IDLE, WRITE, HOLD, RUN};
  - index localparams ROM_INDEX / MOD_INDEX / DIP_INDEX;
  - REGION_W=17.
- One sub-module, rom_region_decode: combinational address to {valid, region one-hot, offset}, reused by the bench's reference model.

Test Plan:
- Reset, then idle 20 cycles with no download -> core_reset=1 for 16 cycles after reset release, then 0; mod=8'hFF; dip_sw=0.
- ROM download of bytes at 0x0000=8'hA5, 0xC000=8'h3C, 0x1C010=8'h77 -> region_we pulses 0001/addr 0, 0010/addr 0, 0100/addr 0x10 with matching data, each one cycle after ioctl_wr.
- region_busy[1]=1 for 5 cycles during a write to 0xC004 -> ioctl_wait high 6 cycles, region_we[1] once with addr 4, data stable.
- Write to 0x20000 -> no region_we, overflow=1, ioctl_wait stays 0; a new download clears overflow.
- DIP index, addr 3 = 8'h5A and addr 9 = 8'hFF -> dip_sw[31:24]=8'h5A, others unchanged; MOD index bytes 2 then 6 -> mod=6; core_reset unaffected.
- Download falls during a busy WRITE -> write completes, then core_reset high 16 cycles, then RUN; reset_n pulse mid-WRITE -> no strobe, core_reset=1.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download scheduler.
package rom_load_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      HOLD,
      RUN
   } state_t;

   localparam logic [7:0] ROM_INDEX = 8'd0;
   localparam logic [7:0] MOD_INDEX = 8'd1;
   localparam logic [7:0] DIP_INDEX = 8'd254;

   localparam int ADDR_W   = 25;
   localparam int REGION_W = 17;

endpackage : rom_load_pkg

// File: rtl/rom_region_decode.sv
// Combinational decode of an ioctl byte address into
// {in-range flag, one-hot region, offset from the region base}.
module rom_region_decode
   import rom_load_pkg::*;
#(
   parameter logic [ADDR_W-1:0] R1_BASE = 25'h0_C000,
   parameter logic [ADDR_W-1:0] R2_BASE = 25'h1_C000,
   parameter logic [ADDR_W-1:0] R3_BASE = 25'h1_D000,
   parameter logic [ADDR_W-1:0] ROM_END = 25'h2_0000
) (
   input  logic [ADDR_W-1:0]   addr,
   output logic                valid,
   output logic [3:0]          region_oh,
   output logic [REGION_W-1:0] offset
);

   logic [ADDR_W-1:0] base;

   // Pick the highest region whose base is at or below the address.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      valid     = (addr < ROM_END);
      region_oh = 4'b0001;
      base      = '0;
      if (addr >= R3_BASE) begin
         region_oh = 4'b1000;
         base      = R3_BASE;
      end else if (addr >= R2_BASE) begin
         region_oh = 4'b0100;
         base      = R2_BASE;
      end else if (addr >= R1_BASE) begin
         region_oh = 4'b0010;
         base      = R1_BASE;
      end
      offset = REGION_W'(addr - base);
   end

endmodule : rom_region_decode

// File: rtl/rom_load_sched.sv
// Sequences the HPS ioctl download into the CPU, gfx, sound and spare ROM
// regions, latches the mod/DIP bytes and owns the game-board reset.
// Optional macro ROM_LOAD_CHECKSUM_EN adds a rom_sum output (16-bit wrapping
// sum of accepted ROM bytes).
module rom_load_sched
   import rom_load_pkg::*;
#(
   parameter logic [ADDR_W-1:0] R1_BASE    = 25'h0_C000,
   parameter logic [ADDR_W-1:0] R2_BASE    = 25'h1_C000,
   parameter logic [ADDR_W-1:0] R3_BASE    = 25'h1_D000,
   parameter logic [ADDR_W-1:0] ROM_END    = 25'h2_0000,
   parameter int                RESET_HOLD = 16
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                ioctl_download,
   input  logic                ioctl_wr,
   input  logic [ADDR_W-1:0]   ioctl_addr,
   input  logic [7:0]          ioctl_dout,
   input  logic [7:0]          ioctl_index,
   output logic                ioctl_wait,
   input  logic [3:0]          region_busy,
   output logic [3:0]          region_we,
   output logic [REGION_W-1:0] region_addr,
   output logic [7:0]          region_data,
   output logic                core_reset,
   output logic [7:0]          mod,
   output logic [63:0]         dip_sw,
   output logic                overflow
`ifdef ROM_LOAD_CHECKSUM_EN
   ,
   output logic [15:0]         rom_sum
`endif
);

   localparam int CNT_W = $clog2(RESET_HOLD) + 1;

   state_t              state;
   logic [CNT_W-1:0]    hold_cnt;
   logic [3:0]          wr_oh;
   logic                dec_valid;
   logic [3:0]          dec_oh;
   logic [REGION_W-1:0] dec_off;
   logic                rom_start;
   logic                rom_wr;
   logic                write_done;

   rom_region_decode #(
      .R1_BASE (R1_BASE),
      .R2_BASE (R2_BASE),
      .R3_BASE (R3_BASE),
      .ROM_END (ROM_END)
   ) u_decode (
      .addr      (ioctl_addr),
      .valid     (dec_valid),
      .region_oh (dec_oh),
      .offset    (dec_off)
   );

   assign rom_start = ioctl_download && (ioctl_index == ROM_INDEX);
   assign rom_wr    = rom_start && ioctl_wr;

   // The strobe is gated by the same-cycle busy input so an idle target is
   // written on the first WRITE cycle, one cycle after ioctl_wr.
   assign region_we  = (state == WRITE) ? (wr_oh & ~region_busy) : 4'b0000;
   assign write_done = |region_we;

   // Download / write / reset-hold sequencer with registered outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= HOLD;
         hold_cnt    <= '0;
         ioctl_wait  <= 1'b0;
         wr_oh       <= 4'b0000;
         region_addr <= '0;
         region_data <= '0;
         core_reset  <= 1'b1;
         overflow    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from
         // pre-edge values, independent of statement order.
         case (state)
            RUN: begin
               if (rom_start) begin
                  state      <= IDLE;
                  core_reset <= 1'b1;
                  overflow   <= 1'b0;
               end
            end
            HOLD: begin
               if (rom_start) begin
                  state    <= IDLE;
                  overflow <= 1'b0;
                  hold_cnt <= '0;
               end else if (hold_cnt == CNT_W'(RESET_HOLD - 1)) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (!ioctl_download) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
               end else if (rom_wr) begin
                  if (dec_valid) begin
                     state       <= WRITE;
                     ioctl_wait  <= 1'b1;
                     wr_oh       <= dec_oh;
                     region_addr <= dec_off;
                     region_data <= ioctl_dout;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            WRITE: begin
               // A falling download waits for the pending byte to land.
               if (write_done) begin
                  ioctl_wait <= 1'b0;
                  hold_cnt   <= '0;
                  state      <= ioctl_download ? IDLE : HOLD;
               end
            end
            default: state <= HOLD;
         endcase
      end
   end

   // Mod and DIP bytes are accepted in any state without stalling the HPS.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mod    <= 8'hFF;
         dip_sw <= '0;
      end else if (ioctl_wr) begin
         if (ioctl_index == MOD_INDEX) begin
            mod <= ioctl_dout;
         end else if ((ioctl_index == DIP_INDEX) && (ioctl_addr[ADDR_W-1:3] == '0)) begin
            dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
         end
      end
   end

`ifdef ROM_LOAD_CHECKSUM_EN
   // Running sum of accepted ROM bytes, restarted with each new download.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rom_sum <= '0;
      end else if (((state == RUN) || (state == HOLD)) && rom_start) begin
         rom_sum <= '0;
      end else if ((state == IDLE) && rom_wr && dec_valid) begin
         rom_sum <= rom_sum + 16'(ioctl_dout);
      end
   end
`endif

endmodule : rom_load_sched
